// File: rtl/fetch_unit.sv
// fetch_unit: instruction-fetch stage; owns the PC, drives sync imem,
// issues instr/pc/valid to IF/ID, honours stall and WB redirect.
//
// Ports:
//   clock, reset      rising-edge clock, sync active-high reset
//   stall             hold request from ID
//   redirect          taken branch/jump from WB
//   redirect_pc       target of the redirect
//   imem_addr         combinational read address (low ADDR_W PC bits)
//   imem_data         imem read data, one cycle after imem_addr
//   instr_out, pc_out registered instruction and its PC
//   valid_out         instr_out/pc_out are correct-path
//   fetch_count       number of valid instructions issued
//   bubble_count      number of bubbles issued since reset
module fetch_unit #(
  parameter int          ADDR_W   = 8,
  parameter logic [31:0] RESET_PC = 32'd0
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              stall,
  input  logic              redirect,
  input  logic [31:0]       redirect_pc,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic [31:0]       imem_data,
  output logic [31:0]       instr_out,
  output logic [31:0]       pc_out,
  output logic              valid_out,
  output logic [31:0]       fetch_count,
  output logic [31:0]       bubble_count
);

  logic [31:0] pc;
  logic [31:0] pc_q;
  logic        fvld_q;

  // While stalled, re-read the in-flight address so imem_data keeps
  // returning mem[pc_q] until the held instruction can be consumed.
  assign imem_addr = stall ? pc_q[ADDR_W-1:0] : pc[ADDR_W-1:0];

  always_ff @(posedge clock) begin
    if (reset) begin
      pc           <= RESET_PC;
      pc_q         <= 32'd0;
      fvld_q       <= 1'b0;
      instr_out    <= 32'd0;
      pc_out       <= 32'd0;
      valid_out    <= 1'b0;
      fetch_count  <= 32'd0;
      bubble_count <= 32'd0;
    end else if (redirect) begin
      // Data returning now and next cycle is wrong-path; a stall
      // asserted alongside is moot since that output is dropped.
      pc           <= redirect_pc;
      pc_q         <= pc;
      fvld_q       <= 1'b0;
      valid_out    <= 1'b0;
      bubble_count <= bubble_count + 32'd1;
    end else if (!stall) begin
      pc           <= pc + 32'd1;
      pc_q         <= pc;
      fvld_q       <= 1'b1;
      instr_out    <= imem_data;
      pc_out       <= pc_q;
      valid_out    <= fvld_q;
      fetch_count  <= fetch_count + {31'd0, fvld_q};
      bubble_count <= bubble_count + {31'd0, ~fvld_q};
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: directed self-checking bench for fetch_unit
// with a 256-word synchronous instruction memory model.
module tb_fetch_unit;

  logic        clock = 1'b0;
  logic        reset;
  logic        stall;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic [7:0]  imem_addr;
  logic [31:0] imem_data;
  logic [31:0] instr_out;
  logic [31:0] pc_out;
  logic        valid_out;
  logic [31:0] fetch_count;
  logic [31:0] bubble_count;

  logic [31:0] mem [256];

  int n_run  = 0;
  int n_fail = 0;

  fetch_unit #(.ADDR_W(8), .RESET_PC(32'd0)) dut (
    .clock        (clock),
    .reset        (reset),
    .stall        (stall),
    .redirect     (redirect),
    .redirect_pc  (redirect_pc),
    .imem_addr    (imem_addr),
    .imem_data    (imem_data),
    .instr_out    (instr_out),
    .pc_out       (pc_out),
    .valid_out    (valid_out),
    .fetch_count  (fetch_count),
    .bubble_count (bubble_count)
  );

  always #5 clock = ~clock;

  always @(posedge clock) imem_data <= mem[imem_addr];

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_run++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %08h expected %08h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  function automatic logic [31:0] m(input int a);
    return 32'h1000_0000 + a;
  endfunction

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 32'h1000_0000 + i;
    reset = 1'b1;
    stall = 1'b0;
    redirect = 1'b0;
    redirect_pc = 32'd0;
    step();
    step();
    chk("rst_valid", {31'd0, valid_out}, 32'd0);
    chk("rst_pc", pc_out, 32'd0);
    chk("rst_instr", instr_out, 32'd0);
    chk("rst_fcnt", fetch_count, 32'd0);
    chk("rst_bcnt", bubble_count, 32'd0);
    reset = 1'b0;

    // E1: one bubble
    step();
    chk("e1_valid", {31'd0, valid_out}, 32'd0);
    chk("e1_bcnt", bubble_count, 32'd1);
    for (int k = 0; k < 3; k++) begin
      step();
      chk("seq_valid", {31'd0, valid_out}, 32'd1);
      chk("seq_pc", pc_out, k);
      chk("seq_instr", instr_out, m(k));
    end

    // stall 3 cycles with pc_out=2
    stall = 1'b1;
    #1;
    chk("stall_addr", {24'd0, imem_addr}, 32'd3);
    for (int k = 0; k < 3; k++) begin
      step();
      chk("stall_pc", pc_out, 32'd2);
      chk("stall_instr", instr_out, m(2));
      chk("stall_valid", {31'd0, valid_out}, 32'd1);
      chk("stall_addr_h", {24'd0, imem_addr}, 32'd3);
    end
    stall = 1'b0;
    for (int k = 3; k < 5; k++) begin
      step();
      chk("post_pc", pc_out, k);
      chk("post_instr", instr_out, m(k));
    end
    chk("p1_fcnt", fetch_count, 32'd5);
    chk("p1_bcnt", bubble_count, 32'd1);
    step();
    chk("pc5", pc_out, 32'd5);

    // redirect to 0x40
    redirect = 1'b1;
    redirect_pc = 32'h40;
    step();
    redirect = 1'b0;
    chk("r1_valid", {31'd0, valid_out}, 32'd0);
    chk("r1_pc_hold", pc_out, 32'd5);
    step();
    chk("r2_valid", {31'd0, valid_out}, 32'd0);
    step();
    chk("r3_valid", {31'd0, valid_out}, 32'd1);
    chk("r3_pc", pc_out, 32'h40);
    chk("r3_instr", instr_out, m(32'h40));
    step();
    chk("r4_pc", pc_out, 32'h41);
    chk("r4_instr", instr_out, m(32'h41));
    chk("r_fcnt", fetch_count, 32'd8);
    chk("r_bcnt", bubble_count, 32'd3);

    // redirect + stall together to 0x10
    redirect = 1'b1;
    stall = 1'b1;
    redirect_pc = 32'h10;
    step();
    redirect = 1'b0;
    stall = 1'b0;
    chk("rs1_valid", {31'd0, valid_out}, 32'd0);
    step();
    chk("rs2_valid", {31'd0, valid_out}, 32'd0);
    step();
    chk("rs3_valid", {31'd0, valid_out}, 32'd1);
    chk("rs3_pc", pc_out, 32'h10);
    chk("rs3_instr", instr_out, m(32'h10));
    chk("rs_bcnt", bubble_count, 32'd5);

    // redirect to top of address space: PC wraps
    redirect = 1'b1;
    redirect_pc = 32'hFFFF_FFFF;
    step();
    redirect = 1'b0;
    #1;
    chk("w_addr_ff", {24'd0, imem_addr}, 32'hFF);
    step();
    chk("w_addr_00", {24'd0, imem_addr}, 32'h00);
    chk("w2_valid", {31'd0, valid_out}, 32'd0);
    step();
    chk("w_pc_max", pc_out, 32'hFFFF_FFFF);
    chk("w_instr_max", instr_out, m(255));
    chk("w_valid", {31'd0, valid_out}, 32'd1);
    step();
    chk("w_pc_0", pc_out, 32'd0);
    chk("w_instr_0", instr_out, m(0));
    chk("w_fcnt", fetch_count, 32'd11);
    chk("w_bcnt", bubble_count, 32'd7);

    // run to pc_out=7, stall, then reset mid-stall
    for (int k = 1; k < 8; k++) step();
    chk("pc7", pc_out, 32'd7);
    stall = 1'b1;
    step();
    chk("s7_pc", pc_out, 32'd7);
    reset = 1'b1;
    step();
    chk("rs_valid", {31'd0, valid_out}, 32'd0);
    chk("rs_fcnt", fetch_count, 32'd0);
    chk("rs_bcnt0", bubble_count, 32'd0);
    reset = 1'b0;
    stall = 1'b0;
    step();
    chk("rr1_valid", {31'd0, valid_out}, 32'd0);
    chk("rr1_bcnt", bubble_count, 32'd1);
    step();
    chk("rr2_valid", {31'd0, valid_out}, 32'd1);
    chk("rr2_pc", pc_out, 32'd0);
    chk("rr2_instr", instr_out, m(0));
    chk("rr2_fcnt", fetch_count, 32'd1);

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
